// File: rtl/powerup_pkg.sv
// Shared types and helpers for the maze power-up scheduler.
// Slot state encoding, slot indices and the sprite overlap test.
package powerup_pkg;

    localparam int unsigned COORD_W     = 32;
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned EXT_W       = COORD_W + 1;
    localparam int unsigned NUM_SLOTS   = 2;
    localparam int unsigned NUM_PLAYERS = 2;

    localparam int unsigned SLOT_SPEED = 0;
    localparam int unsigned SLOT_FAKE  = 1;

    localparam logic [COORD_W-1:0] HIDDEN_COORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        HELD     = 2'd1,
        COOLDOWN = 2'd2
    } slot_state_e;

    // Inclusive box test, widened by one bit so px+W and ux+W cannot wrap.
    function automatic logic sprite_overlap(
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] ux,
        input logic [COORD_W-1:0] uy,
        input logic [EXT_W-1:0]   w,
        input logic [EXT_W-1:0]   h
    );
        logic [EXT_W-1:0] px_e;
        logic [EXT_W-1:0] py_e;
        logic [EXT_W-1:0] ux_e;
        logic [EXT_W-1:0] uy_e;
        px_e = {1'b0, px};
        py_e = {1'b0, py};
        ux_e = {1'b0, ux};
        uy_e = {1'b0, uy};
        return ((px_e + w) >= ux_e) && (px_e <= (ux_e + w)) &&
               ((py_e + h) >= uy_e) && (py_e <= (uy_e + h));
    endfunction

endpackage

// File: rtl/powerup_slot.sv
// One power-up slot: lifecycle FSM, effect duration and respawn counters,
// owner tracking and the registered coordinate/effect/pulse outputs.
module powerup_slot
    import powerup_pkg::*;
#(
    parameter int unsigned SPAWN_X         = 300,
    parameter int unsigned SPAWN_Y         = 300,
    parameter int unsigned TICKS_PER_STAGE = 100000000,
    parameter int unsigned NUM_STAGES      = 7,
    parameter int unsigned RESPAWN_TICKS   = 500000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_pause,
    input  logic               i_grant,
    input  logic               i_grant_player,
    output logic               o_active_c,
    output logic [COORD_W-1:0] o_pos_x,
    output logic [COORD_W-1:0] o_pos_y,
    output logic [1:0]         o_effect,
    output logic               o_pickup_pulse,
    output logic               o_pickup_player
);

    localparam logic [CNT_W-1:0]   TICK_LAST    = CNT_W'(TICKS_PER_STAGE - 1);
    localparam logic [CNT_W-1:0]   STAGE_LAST   = CNT_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(RESPAWN_TICKS - 1);
    localparam logic [COORD_W-1:0] SPAWN_XC     = COORD_W'(SPAWN_X);
    localparam logic [COORD_W-1:0] SPAWN_YC     = COORD_W'(SPAWN_Y);

    slot_state_e        r_state;
    slot_state_e        w_state_nxt;
    logic [CNT_W-1:0]   r_tick;
    logic [CNT_W-1:0]   w_tick_nxt;
    logic [CNT_W-1:0]   r_stage;
    logic [CNT_W-1:0]   w_stage_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_owner;
    logic               w_owner_nxt;
    logic [COORD_W-1:0] r_pos_x;
    logic [COORD_W-1:0] w_pos_x_nxt;
    logic [COORD_W-1:0] r_pos_y;
    logic [COORD_W-1:0] w_pos_y_nxt;
    logic [1:0]         r_effect;
    logic [1:0]         w_effect_nxt;
    logic               r_pulse;
    logic               w_pulse_nxt;
    logic               r_player;
    logic               w_player_nxt;

    // State and output registers; reset returns the slot to its spawn point.
    always_ff @(negedge clock) begin
        if (reset) begin
            r_state  <= ACTIVE;
            r_tick   <= '0;
            r_stage  <= '0;
            r_cnt    <= '0;
            r_owner  <= 1'b0;
            r_pos_x  <= SPAWN_XC;
            r_pos_y  <= SPAWN_YC;
            r_effect <= 2'b00;
            r_pulse  <= 1'b0;
            r_player <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_stage  <= w_stage_nxt;
            r_cnt    <= w_cnt_nxt;
            r_owner  <= w_owner_nxt;
            r_pos_x  <= w_pos_x_nxt;
            r_pos_y  <= w_pos_y_nxt;
            r_effect <= w_effect_nxt;
            r_pulse  <= w_pulse_nxt;
            r_player <= w_player_nxt;
        end
    end

    // Next-state and next-output logic; pause freezes everything but the pulse.
    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick;
        w_stage_nxt  = r_stage;
        w_cnt_nxt    = r_cnt;
        w_owner_nxt  = r_owner;
        w_pos_x_nxt  = r_pos_x;
        w_pos_y_nxt  = r_pos_y;
        w_effect_nxt = r_effect;
        w_pulse_nxt  = 1'b0;
        w_player_nxt = r_player;

        if (!i_pause) begin
            case (r_state)
                ACTIVE: begin
                    if (i_grant) begin
                        w_state_nxt  = HELD;
                        w_tick_nxt   = '0;
                        w_stage_nxt  = '0;
                        w_owner_nxt  = i_grant_player;
                        w_pos_x_nxt  = HIDDEN_COORD;
                        w_pos_y_nxt  = HIDDEN_COORD;
                        w_effect_nxt = i_grant_player ? 2'b10 : 2'b01;
                        w_pulse_nxt  = 1'b1;
                        w_player_nxt = i_grant_player;
                    end
                end
                HELD: begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nxt = '0;
                        if (r_stage == STAGE_LAST) begin
                            w_state_nxt  = COOLDOWN;
                            w_stage_nxt  = '0;
                            w_cnt_nxt    = '0;
                            w_effect_nxt = 2'b00;
                        end else begin
                            w_stage_nxt = r_stage + CNT_W'(1);
                        end
                    end else begin
                        w_tick_nxt = r_tick + CNT_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (r_cnt == RESPAWN_LAST) begin
                        w_state_nxt = ACTIVE;
                        w_cnt_nxt   = '0;
                        w_pos_x_nxt = SPAWN_XC;
                        w_pos_y_nxt = SPAWN_YC;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt  = ACTIVE;
                    w_pos_x_nxt  = SPAWN_XC;
                    w_pos_y_nxt  = SPAWN_YC;
                    w_effect_nxt = 2'b00;
                end
            endcase
        end
    end

    assign o_active_c      = (r_state == ACTIVE);
    assign o_pos_x         = r_pos_x;
    assign o_pos_y         = r_pos_y;
    assign o_effect        = r_effect;
    assign o_pickup_pulse  = r_pulse;
    assign o_pickup_player = r_player;

endmodule

// File: rtl/powerup_scheduler.sv
// Two-slot power-up scheduler: player/slot overlap detection, round-robin
// arbitration of contested pickups and fan-out of the per-slot outputs.
module powerup_scheduler
    import powerup_pkg::*;
#(
    parameter int unsigned SPRITE_W        = 25,
    parameter int unsigned SPRITE_H        = 25,
    parameter int unsigned TICKS_PER_STAGE = 100000000,
    parameter int unsigned NUM_STAGES      = 7,
    parameter int unsigned RESPAWN_TICKS   = 500000000,
    parameter int unsigned SPAWN0_X        = 300,
    parameter int unsigned SPAWN0_Y        = 300,
    parameter int unsigned SPAWN1_X        = 400,
    parameter int unsigned SPAWN1_Y        = 400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pause,
    input  logic [31:0] player0_x,
    input  logic [31:0] player0_y,
    input  logic [31:0] player1_x,
    input  logic [31:0] player1_y,
    output logic [31:0] powerup0_x,
    output logic [31:0] powerup0_y,
    output logic [31:0] powerup1_x,
    output logic [31:0] powerup1_y,
    output logic [1:0]  p0_effect,
    output logic [1:0]  p1_effect,
    output logic [1:0]  pickup_pulse,
    output logic [1:0]  pickup_player
);

    localparam logic [EXT_W-1:0] W_EXT = EXT_W'(SPRITE_W);
    localparam logic [EXT_W-1:0] H_EXT = EXT_W'(SPRITE_H);

    logic [NUM_SLOTS-1:0] w_active;
    logic [COORD_W-1:0]   w_pos_x [NUM_SLOTS];
    logic [COORD_W-1:0]   w_pos_y [NUM_SLOTS];
    logic [1:0]           w_effect [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_pulse;
    logic [NUM_SLOTS-1:0] w_player;

    logic [NUM_SLOTS-1:0] w_hit0;
    logic [NUM_SLOTS-1:0] w_hit1;
    logic [NUM_SLOTS-1:0] w_grant;
    logic [NUM_SLOTS-1:0] w_contest;
    logic [NUM_SLOTS-1:0] w_winner;
    logic                 r_rr_prio;

    // Overlap only matters while a slot sits on the map; its coords then equal spawn.
    always_comb begin
        w_hit0[SLOT_SPEED] = w_active[SLOT_SPEED] &&
            sprite_overlap(player0_x, player0_y, w_pos_x[SLOT_SPEED], w_pos_y[SLOT_SPEED], W_EXT, H_EXT);
        w_hit1[SLOT_SPEED] = w_active[SLOT_SPEED] &&
            sprite_overlap(player1_x, player1_y, w_pos_x[SLOT_SPEED], w_pos_y[SLOT_SPEED], W_EXT, H_EXT);
        w_hit0[SLOT_FAKE]  = w_active[SLOT_FAKE] &&
            sprite_overlap(player0_x, player0_y, w_pos_x[SLOT_FAKE], w_pos_y[SLOT_FAKE], W_EXT, H_EXT);
        w_hit1[SLOT_FAKE]  = w_active[SLOT_FAKE] &&
            sprite_overlap(player1_x, player1_y, w_pos_x[SLOT_FAKE], w_pos_y[SLOT_FAKE], W_EXT, H_EXT);
    end

    // Contested slot0 takes rr_prio; slot1 takes the opposite when slot0 is also contested.
    always_comb begin
        w_grant   = {NUM_SLOTS{~pause}} & (w_hit0 | w_hit1);
        w_contest = {NUM_SLOTS{~pause}} & w_hit0 & w_hit1;
        w_winner  = w_hit1;
        if (w_contest[SLOT_SPEED]) begin
            w_winner[SLOT_SPEED] = r_rr_prio;
        end
        if (w_contest[SLOT_FAKE]) begin
            w_winner[SLOT_FAKE] = w_contest[SLOT_SPEED] ? ~r_rr_prio : r_rr_prio;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            r_rr_prio <= 1'b0;
        end else if (|w_contest) begin
            r_rr_prio <= ~r_rr_prio;
        end
    end

    powerup_slot #(
        .SPAWN_X         (SPAWN0_X),
        .SPAWN_Y         (SPAWN0_Y),
        .TICKS_PER_STAGE (TICKS_PER_STAGE),
        .NUM_STAGES      (NUM_STAGES),
        .RESPAWN_TICKS   (RESPAWN_TICKS)
    ) u_slot_speed (
        .clock           (clock),
        .reset           (reset),
        .i_pause         (pause),
        .i_grant         (w_grant[SLOT_SPEED]),
        .i_grant_player  (w_winner[SLOT_SPEED]),
        .o_active_c      (w_active[SLOT_SPEED]),
        .o_pos_x         (w_pos_x[SLOT_SPEED]),
        .o_pos_y         (w_pos_y[SLOT_SPEED]),
        .o_effect        (w_effect[SLOT_SPEED]),
        .o_pickup_pulse  (w_pulse[SLOT_SPEED]),
        .o_pickup_player (w_player[SLOT_SPEED])
    );

    powerup_slot #(
        .SPAWN_X         (SPAWN1_X),
        .SPAWN_Y         (SPAWN1_Y),
        .TICKS_PER_STAGE (TICKS_PER_STAGE),
        .NUM_STAGES      (NUM_STAGES),
        .RESPAWN_TICKS   (RESPAWN_TICKS)
    ) u_slot_fake (
        .clock           (clock),
        .reset           (reset),
        .i_pause         (pause),
        .i_grant         (w_grant[SLOT_FAKE]),
        .i_grant_player  (w_winner[SLOT_FAKE]),
        .o_active_c      (w_active[SLOT_FAKE]),
        .o_pos_x         (w_pos_x[SLOT_FAKE]),
        .o_pos_y         (w_pos_y[SLOT_FAKE]),
        .o_effect        (w_effect[SLOT_FAKE]),
        .o_pickup_pulse  (w_pulse[SLOT_FAKE]),
        .o_pickup_player (w_player[SLOT_FAKE])
    );

    assign powerup0_x    = w_pos_x[SLOT_SPEED];
    assign powerup0_y    = w_pos_y[SLOT_SPEED];
    assign powerup1_x    = w_pos_x[SLOT_FAKE];
    assign powerup1_y    = w_pos_y[SLOT_FAKE];
    assign p0_effect     = {w_effect[SLOT_FAKE][0], w_effect[SLOT_SPEED][0]};
    assign p1_effect     = {w_effect[SLOT_FAKE][1], w_effect[SLOT_SPEED][1]};
    assign pickup_pulse  = w_pulse;
    assign pickup_player = w_player;

endmodule
